// File: rtl/mem_wb_writeback.sv
// -----------------------------------------------------------------------------
// mem_wb_writeback
//
// Write-back end of the five-stage pipeline. Holds the MEM/WB pipeline
// register, selects the write-back value, commits it into the 32-entry
// architectural register file and counts retired instructions. The registered
// MEM_WB_* outputs also feed the ID-stage forwarding unit.
//
// Parameters
//   DATA_W            datapath and register width
//   CNT_W             retired-instruction counter width
//
// Ports
//   clk_i             clock, all state updates on the rising edge
//   rst_i             asynchronous active-high reset
//   stall_i           hold MEM/WB contents, suppress commit
//   flush_i           load a bubble into MEM/WB (overrides stall_i)
//   EX_MEM_*          instruction leaving MEM
//   MEM_ReadData      data-memory read data, same cycle as EX_MEM_*
//   IF_ID_RegisterRs  read address A      -> RsData
//   IF_ID_RegisterRt  read address B      -> RtData
//   MEM_WB_Valid      instruction present in WB
//   MEM_WB_RegWrite   registered RegWrite qualified by Valid
//   MEM_WB_RegisterRd registered destination register
//   MEM_WB_WriteData  selected write-back value
//   RetiredCount      number of committed instructions (wraps)
// -----------------------------------------------------------------------------
module mem_wb_writeback #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              EX_MEM_Valid,
  input  logic              EX_MEM_RegWrite,
  input  logic              EX_MEM_MemtoReg,
  input  logic [4:0]        EX_MEM_RegisterRd,
  input  logic [DATA_W-1:0] EX_MEM_ALUResult,
  input  logic [DATA_W-1:0] MEM_ReadData,
  input  logic [4:0]        IF_ID_RegisterRs,
  input  logic [4:0]        IF_ID_RegisterRt,
  output logic [DATA_W-1:0] RsData,
  output logic [DATA_W-1:0] RtData,
  output logic              MEM_WB_Valid,
  output logic              MEM_WB_RegWrite,
  output logic [4:0]        MEM_WB_RegisterRd,
  output logic [DATA_W-1:0] MEM_WB_WriteData,
  output logic [CNT_W-1:0]  RetiredCount
);

  // MEM/WB pipeline register fields
  logic              valid_q;
  logic              regwrite_q;
  logic              memtoreg_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] regs [32];
  logic [CNT_W-1:0]  retired_q;

  logic              commit;
  logic              reg_we;

  // The instruction in WB retires whenever it is valid and the pipe advances.
  // A flush moves the pipe even under stall, so the occupant still commits.
  assign commit = valid_q & (flush_i | ~stall_i);
  assign reg_we = commit & regwrite_q & (rd_q != 5'd0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      rd_q       <= 5'd0;
      alu_q      <= '0;
      rdata_q    <= '0;
    end else if (flush_i) begin
      // Bubble: only the qualifying bits are cleared, payload is don't-care.
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
    end else if (!stall_i) begin
      valid_q    <= EX_MEM_Valid;
      regwrite_q <= EX_MEM_RegWrite;
      memtoreg_q <= EX_MEM_MemtoReg;
      rd_q       <= EX_MEM_RegisterRd;
      alu_q      <= EX_MEM_ALUResult;
      rdata_q    <= MEM_ReadData;
    end
  end

  // NOTE: the register file must read 0 after reset, so this array is reset
  // explicitly; that keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (reg_we) begin
      regs[rd_q] <= MEM_WB_WriteData;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retired_q <= '0;
    end else if (commit) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  // Write-back mux sits after the register so the forwarding unit sees the
  // final value in the same cycle it is committed.
  assign MEM_WB_WriteData  = memtoreg_q ? rdata_q : alu_q;
  assign MEM_WB_Valid      = valid_q;
  assign MEM_WB_RegWrite   = regwrite_q & valid_q;
  assign MEM_WB_RegisterRd = rd_q;
  assign RetiredCount      = retired_q;

  // Reads see stored state only; a same-cycle write reaches ID through the
  // forwarding unit, not through this port. $0 is hard-wired to zero.
  assign RsData = (IF_ID_RegisterRs == 5'd0) ? '0 : regs[IF_ID_RegisterRs];
  assign RtData = (IF_ID_RegisterRt == 5'd0) ? '0 : regs[IF_ID_RegisterRt];

endmodule

// File: doc/mem_wb_writeback.md
# mem_wb_writeback

Write-back end of the five-stage pipeline: the MEM/WB pipeline register plus the 32-entry architectural register file it writes. It captures each instruction leaving MEM and selects the write-back value. It drives MEM_WB_RegWrite / MEM_WB_RegisterRd / MEM_WB_WriteData, which the ID-stage forwarding unit consumes, and commits the value into the register file. It also serves the ID-stage Rs/Rt reads and counts retired instructions.

## Interface
- DATA_W, 32, datapath and register width
- CNT_W, 32, retired-instruction counter width
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- stall_i  in  1  hold MEM/WB contents; suppress commit
- flush_i  in  1  load a bubble into MEM/WB
- EX_MEM_Valid  in  1  instruction present in MEM
- EX_MEM_RegWrite  in  1  instruction writes a register
- EX_MEM_MemtoReg  in  1  1 = write load data, 0 = write ALU result
- EX_MEM_RegisterRd  in  5  destination register
- EX_MEM_ALUResult  in  DATA_W  ALU result
- MEM_ReadData  in  DATA_W  data-memory read data, same cycle as EX_MEM_*
- IF_ID_RegisterRs  in  5  read address A
- IF_ID_RegisterRt  in  5  read address B
- RsData  out  DATA_W  register-file content at Rs
- RtData  out  DATA_W  register-file content at Rt
- MEM_WB_Valid  out  1  instruction present in WB
- MEM_WB_RegWrite  out  1  registered RegWrite, forced 0 when not valid
- MEM_WB_RegisterRd  out  5  registered destination
- MEM_WB_WriteData  out  DATA_W  selected write-back value
- RetiredCount  out  CNT_W  number of committed instructions

## Operation
- MEM/WB register fields: Valid, RegWrite, MemtoReg, RegisterRd, ALUResult, ReadData.
- Each rising edge, in priority order:
  - **rst_i (async):** all fields 0.
  - **flush_i:** Valid=0, RegWrite=0. Other fields don't-care; hold them.
  - **stall_i:** hold all fields.
  - **Otherwise:** load from EX_MEM_* and MEM_ReadData.
- MEM_WB_WriteData = MemtoReg ? ReadData : ALUResult. This is a combinational mux after the register.
- MEM_WB_RegWrite = RegWrite & Valid.
- Commit: at a rising edge where MEM_WB_Valid=1 and stall_i=0.
  - If MEM_WB_RegWrite=1 and MEM_WB_RegisterRd≠0, write MEM_WB_WriteData into regs[Rd].
  - RetiredCount increments by 1, whether or not the instruction writes a register.
  - flush_i does not block the commit of the instruction currently in WB; it only affects what is loaded.
- Register file: 32 x DATA_W. Entry 0 reads 0 always and is never written.
- RsData/RtData are combinational reads of stored state. There is no internal write-through bypass: a same-cycle WB write is visible in ID only through the ID forwarding unit, and in the register file from the next cycle on.
- RetiredCount wraps from 2^CNT_W−1 to 0.

## Timing
- Reset values:
  - All outputs 0 (MEM_WB_* 0, RetiredCount 0).
  - All 32 registers 0, so RsData/RtData read 0.
  - Async reset asserted mid-operation clears immediately and discards any pending commit. The first commit after release is possible at the second rising edge after deassertion.
- MEM→WB latency: 1 cycle. Register-file update: at the commit edge. Read visibility: the cycle after the commit edge.
- Stall held N cycles: MEM_WB_* outputs stay stable; exactly one commit occurs, at the first edge with stall_i=0.
- stall_i and flush_i together: flush wins.
- Back-to-back writes to the same Rd: the later one wins; each is counted once.

## Test plan
- Reset mid-stream:
  - Stimulus: with regs populated and RetiredCount=5, assert rst_i between edges.
  - Required response: outputs go 0 without a clock edge; reading r1..r31 returns 0.
- ALU write then read:
  - Stimulus: EX_MEM Valid=1, RegWrite=1, MemtoReg=0, Rd=8, ALUResult=0x1234 at edge k.
  - Required response: MEM_WB_WriteData=0x1234 and MEM_WB_RegisterRd=8 after edge k. Reading Rs=8 returns 0x1234 after edge k+1. RetiredCount=1.
- Load path and $0:
  - Stimulus: MemtoReg=1, ReadData=0xDEADBEEF, Rd=3; then the same with Rd=0.
  - Required response: r3=0xDEADBEEF; r0 reads 0; RetiredCount=2.
- Stall:
  - Stimulus: Rd=5, value 0x77 in WB; stall_i high for 3 cycles with changing EX_MEM inputs.
  - Required response: MEM_WB outputs constant; r5 stays at its old value until the first unstalled edge, then 0x77; count +1 only.
- Flush with a commit in WB:
  - Stimulus: instruction with Rd=9 in WB; flush_i and stall_i both high for one edge.
  - Required response: r9 written, count +1; MEM_WB_Valid=0 and MEM_WB_RegWrite=0 afterward.
- Counter wrap:
  - Stimulus: preload RetiredCount=0xFFFFFFFF via 2^32−1 commits (force in bench); commit once more.
  - Required response: RetiredCount=0.
